ctech_lib_cdc_req_ack_src: RTL and testbench

//  Source-side controller for a 4-phase req/ack bus crossing built on the ctech double-sync cells.
//  - Accepts a WIDTH-bit word on a valid/ready port and holds it stable on xdata.
//  - Raises xreq and waits for the destination ack, brought into clk through an internal
//    2-flop ctech double-sync. Drops xreq, then waits for ack to return low.
//  - Sits in the source clock domain; the paired destination block lives in the ack domain.
//  - Reports completion with a one-cycle pulse, and flags hung handshakes with a sticky error.

---
 rtl/ctech_lib_cdc_req_ack_src.sv | 153 +++++++++++++++
 tb/tb_ctech_lib_cdc_req_ack_src.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ctech_lib_cdc_req_ack_src.sv
// Source-side controller for a 4-phase req/ack clock-domain crossing.
// A word taken on the valid/ready port is held on xdata while xreq is raised.
// The destination ack is brought into clk through a 2-flop double-sync.
// xreq drops once the synchronised ack is seen high. The controller then waits
// for the synchronised ack to return low, and signals completion with a
// one-cycle done pulse.
// A per-phase cycle counter flags hung handshakes on the sticky timeout_err.
module ctech_lib_cdc_req_ack_src #(
  parameter int WIDTH       = 1,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             xreq,
  output logic [WIDTH-1:0] xdata,
  input  logic             xack,
  output logic             done,
  output logic             timeout_err,
  input  logic             err_clr
);

  // Phase counter has one bit of headroom so it can run past TIMEOUT_CYC and saturate.
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ_HI = 2'd1,
    ST_REQ_LO = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             xreq_q, xreq_d;
  logic [WIDTH-1:0] xdata_q, xdata_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ack_meta_q;
  logic             ack_s_q;
  logic             err_set_s;

  // Double-sync of the asynchronous destination ack into clk.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
    end else begin
      ack_meta_q <= xack;
      ack_s_q    <= ack_meta_q;
    end
  end

  // Next-state logic for the handshake FSM and its registered outputs.
  always_comb begin
    state_d = state_q;
    xreq_d  = xreq_q;
    xdata_d = xdata_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The ack is ignored here; only an offered word starts a transfer.
        if (in_valid) begin
          xdata_d = in_data;
          xreq_d  = 1'b1;
          state_d = ST_REQ_HI;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ_HI: begin
        if (ack_s_q) begin
          xreq_d  = 1'b0;
          state_d = ST_REQ_LO;
        end else begin
          state_d = ST_REQ_HI;
        end
      end
      ST_REQ_LO: begin
        if (!ack_s_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REQ_LO;
        end
      end
      default: begin
        xreq_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    in_ready_d = (state_d == ST_IDLE);
  end

  // Phase counter: zero in IDLE and on every transition, otherwise saturating count.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == ST_IDLE) || (state_d != state_q)) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Sticky timeout flag: sets on the edge that completes TIMEOUT_CYC cycles in a phase;
  // a set outranks a simultaneous clear.
  always_comb begin
    err_set_s = (TIMEOUT_CYC != 0) && (state_q != ST_IDLE) &&
                (state_d == state_q) && (cnt_d == CNT_LIM);
    if (err_set_s) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b1;
      xreq_q     <= 1'b0;
      xdata_q    <= {WIDTH{1'b0}};
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      xreq_q     <= xreq_d;
      xdata_q    <= xdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign xreq        = xreq_q;
  assign xdata       = xdata_q;
  assign done        = done_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_ctech_lib_cdc_req_ack_src.sv
// Bench for ctech_lib_cdc_req_ack_src: WIDTH=8, TIMEOUT_CYC=10.
// A behavioural destination raises and drops ack after programmable delays.
// Words are pushed to a queue when offered and popped when xreq rises.
module tb_ctech_lib_cdc_req_ack_src;

  logic       clk;
  logic       rstb;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       xreq;
  logic [7:0] xdata;
  logic       xack;
  logic       done;
  logic       timeout_err;
  logic       err_clr;

  logic       ack_r;
  logic       glitch_r;
  assign xack = ack_r | glitch_r;

  ctech_lib_cdc_req_ack_src #(.WIDTH(8), .TIMEOUT_CYC(10)) dut (
    .clk(clk), .rstb(rstb), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .xreq(xreq), .xdata(xdata), .xack(xack),
    .done(done), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         dhi;
    int         dlo;
    int         lat;
  } vec_t;

  int         n_cmp;
  int         n_fail;
  logic [7:0] exp_q[$];
  logic       xreq_prev;
  logic [7:0] xdata_prev;
  int         ack_dly_hi;
  int         ack_dly_lo;
  int         wc;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One clock: sample #1 after the edge, run the scoreboard, then step the destination model.
  task automatic tick();
    logic [7:0] e;
    @(posedge clk);
    #1;
    if (rstb) begin
      if (xreq && !xreq_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_xfer", {24'd0, xdata}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("xdata_order", {24'd0, xdata}, {24'd0, e});
        end
      end
      if (xreq && xreq_prev) check("xdata_stable", {24'd0, xdata}, {24'd0, xdata_prev});
    end
    xreq_prev  = xreq;
    xdata_prev = xdata;
    if (!rstb) begin
      ack_r = 1'b0;
      wc    = 0;
    end else if (xreq && !ack_r) begin
      if (wc >= ack_dly_hi) begin ack_r = 1'b1; wc = 0; end else wc++;
    end else if (!xreq && ack_r) begin
      if (wc >= ack_dly_lo) begin ack_r = 1'b0; wc = 0; end else wc++;
    end else begin
      wc = 0;
    end
  endtask

  task automatic send_word(input logic [7:0] d);
    int i;
    exp_q.push_back(d);
    in_data  = d;
    in_valid = 1'b1;
    i = 0;
    while (i < 50) begin
      tick();
      i++;
      if (xreq) break;
    end
    if (!xreq) check("accept_timeout", {31'd0, xreq}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int exp_lat);
    int lat;
    lat = 0;
    while (lat < 300) begin
      tick();
      lat++;
      if (done) break;
    end
    check(nm, lat, exp_lat);
  endtask

  vec_t vecs[6];

  initial begin
    n_cmp = 0; n_fail = 0;
    rstb = 1'b0; in_valid = 1'b0; in_data = 8'h00; err_clr = 1'b0;
    ack_r = 1'b0; glitch_r = 1'b0; xreq_prev = 1'b0; xdata_prev = 8'h00;
    ack_dly_hi = 0; ack_dly_lo = 0; wc = 0;

    vecs[0] = '{data: 8'hA5, dhi: 3,  dlo: 3,  lat: 12};
    vecs[1] = '{data: 8'h00, dhi: 0,  dlo: 0,  lat: 6};
    vecs[2] = '{data: 8'hFF, dhi: 0,  dlo: 5,  lat: 11};
    vecs[3] = '{data: 8'h5A, dhi: 7,  dlo: 0,  lat: 13};
    vecs[4] = '{data: 8'h01, dhi: 2,  dlo: 9,  lat: 17};
    vecs[5] = '{data: 8'h80, dhi: 20, dlo: 20, lat: 46};

    // Reset state
    tick(); tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_xreq", {31'd0, xreq}, 32'd0);
    check("rst_xdata", {24'd0, xdata}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, timeout_err}, 32'd0);
    rstb = 1'b1;
    tick();

    // Table of single transfers with assorted ack delays
    for (int v = 0; v < 6; v++) begin
      ack_dly_hi = vecs[v].dhi;
      ack_dly_lo = vecs[v].dlo;
      send_word(vecs[v].data);
      wait_done("latency", vecs[v].lat);
      check("ready_with_done", {31'd0, in_ready}, 32'd1);
      tick();
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("idle_xdata_held", {24'd0, xdata}, {24'd0, vecs[v].data});
    end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("err_cleared", {31'd0, timeout_err}, 32'd0);

    // Back-to-back words with in_valid held
    ack_dly_hi = 1; ack_dly_lo = 1;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    in_data = 8'h11; in_valid = 1'b1;
    tick();
    check("b2b_first_xreq", {31'd0, xreq}, 32'd1);
    in_data = 8'h22;
    wait_done("b2b_lat1", 8);
    tick();
    check("b2b_second_xreq", {31'd0, xreq}, 32'd1);
    in_valid = 1'b0;
    wait_done("b2b_lat2", 8);
    tick();

    // Busy ignore: new offer during REQ_HI is not taken
    ack_dly_hi = 5; ack_dly_lo = 1;
    send_word(8'hA5);
    in_data = 8'hFF; in_valid = 1'b1;
    tick(); tick();
    check("busy_xdata", {24'd0, xdata}, 32'hA5);
    check("busy_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    wait_done("busy_lat", 10);
    tick(); tick(); tick();
    check("busy_no_extra", {31'd0, xreq}, 32'd0);

    // Timeout: ack withheld, flag sets after 10 REQ_HI cycles, late ack still completes
    ack_dly_hi = 100000; ack_dly_lo = 0;
    send_word(8'h5A);
    for (int i = 0; i < 9; i++) tick();
    check("tmo_not_yet", {31'd0, timeout_err}, 32'd0);
    tick();
    check("tmo_set", {31'd0, timeout_err}, 32'd1);
    check("tmo_xreq_held", {31'd0, xreq}, 32'd1);
    ack_dly_hi = 0;
    wait_done("tmo_late_done", 7);
    check("tmo_sticky", {31'd0, timeout_err}, 32'd1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("tmo_clr", {31'd0, timeout_err}, 32'd0);
    ack_dly_hi = 100000;
    send_word(8'h66);
    for (int i = 0; i < 9; i++) tick();
    check("tmo2_not_yet", {31'd0, timeout_err}, 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("tmo_set_wins", {31'd0, timeout_err}, 32'd1);
    ack_dly_hi = 0;
    wait_done("tmo2_done", 7);
    err_clr = 1'b1; tick(); err_clr = 1'b0;

    // Reset during REQ_LO
    ack_dly_hi = 2; ack_dly_lo = 10;
    send_word(8'hC3);
    for (int i = 0; i < 40; i++) begin
      if (!xreq) break;
      tick();
    end
    tick(); tick();
    rstb = 1'b0;
    #1;
    check("mid_rst_xreq", {31'd0, xreq}, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_sync", {30'd0, dut.ack_meta_q, dut.ack_s_q}, 32'd0);
    tick(); tick();
    rstb = 1'b1;
    tick();
    ack_dly_hi = 2; ack_dly_lo = 2;
    send_word(8'h3C);
    wait_done("post_rst_done", 10);
    tick();

    // Glitch ack in IDLE: no transfer and no done
    glitch_r = 1'b1;
    tick();
    glitch_r = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("glitch_xreq", {31'd0, xreq}, 32'd0);
      check("glitch_done", {31'd0, done}, 32'd0);
      check("glitch_ready", {31'd0, in_ready}, 32'd1);
    end

    // Random ack delays over many words
    for (int w = 0; w < 1000; w++) begin
      ack_dly_hi = int'($urandom_range(0, 20));
      ack_dly_lo = int'($urandom_range(0, 20));
      send_word(8'($urandom));
      wait_done("rand_latency", ack_dly_hi + ack_dly_lo + 6);
    end
    tick();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
